// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow line memory between the I-cache and D-cache
// miss/write-back ports. One 128-bit line transaction is granted at a time;
// the winner's request is captured into registered memory-side outputs and
// the memory's ready pulse is steered back to the winner only.
//
// Arbitration: fixed priority (D over I) by default. Define ARB_RR_EN to get
// round-robin between the two ports on simultaneous requests.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   mem_read_I/_D, mem_write_I/_D  cache requests, held until mem_ready_x
//   mem_addr_I/_D, mem_wdata_I/_D  cache line address / write data
//   mem_rdata_I/_D, mem_ready_I/_D read data and one-cycle completion to caches
//   mem_read, mem_write, mem_addr, mem_wdata  registered request to memory
//   mem_rdata, mem_ready         memory read data and completion pulse
//   grant                        01 = I owns memory, 10 = D owns, 00 = none
module mem_arbiter #(
    parameter int AW = 28,
    parameter int DW = 128
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          mem_read_I,
    input  logic          mem_write_I,
    input  logic [AW-1:0] mem_addr_I,
    input  logic [DW-1:0] mem_wdata_I,
    output logic [DW-1:0] mem_rdata_I,
    output logic          mem_ready_I,
    input  logic          mem_read_D,
    input  logic          mem_write_D,
    input  logic [AW-1:0] mem_addr_D,
    input  logic [DW-1:0] mem_wdata_D,
    output logic [DW-1:0] mem_rdata_D,
    output logic          mem_ready_D,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [1:0]    grant
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RELEASE} state_t;

    state_t state, state_nxt;
    logic   pend_i, pend_d, win_d;

`ifdef ARB_RR_EN
    // Set when D should win the next tie; reset favours D.
    logic rr_fav_d;
`endif

    always_comb begin
        pend_i    = mem_read_I | mem_write_I;
        pend_d    = mem_read_D | mem_write_D;
`ifdef ARB_RR_EN
        win_d     = pend_d & (~pend_i | rr_fav_d);
`else
        win_d     = pend_d;
`endif
        state_nxt = state;
        case (state)
            IDLE:    if (pend_i | pend_d) state_nxt = win_d ? GNT_D : GNT_I;
            GNT_I,
            GNT_D:   if (mem_ready) state_nxt = RELEASE;
            // Dead cycle so the finishing cache can drop its request
            // before requests are sampled again.
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef ARB_RR_EN
            rr_fav_d  <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (pend_i | pend_d) begin
                        // Read+write together from one port: write wins.
                        if (win_d) begin
                            mem_write <= mem_write_D;
                            mem_read  <= mem_read_D & ~mem_write_D;
                            mem_addr  <= mem_addr_D;
                            mem_wdata <= mem_wdata_D;
                        end else begin
                            mem_write <= mem_write_I;
                            mem_read  <= mem_read_I & ~mem_write_I;
                            mem_addr  <= mem_addr_I;
                            mem_wdata <= mem_wdata_I;
                        end
`ifdef ARB_RR_EN
                        rr_fav_d <= ~win_d;
`endif
                    end
                end
                GNT_I, GNT_D: begin
                    // Memory cannot abort: only its ready ends the grant,
                    // even if the cache has already dropped its request.
                    if (mem_ready) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data is broadcast; only the ready pulse is steered.
    assign mem_rdata_I = mem_rdata;
    assign mem_rdata_D = mem_rdata;
    assign mem_ready_I = (state == GNT_I) & mem_ready;
    assign mem_ready_D = (state == GNT_D) & mem_ready;
    assign grant       = {state == GNT_D, state == GNT_I};

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk;
    logic          rst_n;
    logic          mem_read_I, mem_write_I, mem_read_D, mem_write_D;
    logic [AW-1:0] mem_addr_I, mem_addr_D, mem_addr;
    logic [DW-1:0] mem_wdata_I, mem_wdata_D, mem_wdata;
    logic [DW-1:0] mem_rdata_I, mem_rdata_D, mem_rdata;
    logic          mem_ready_I, mem_ready_D, mem_ready;
    logic          mem_read, mem_write;
    logic [1:0]    grant;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_I(mem_read_I), .mem_write_I(mem_write_I),
        .mem_addr_I(mem_addr_I), .mem_wdata_I(mem_wdata_I),
        .mem_rdata_I(mem_rdata_I), .mem_ready_I(mem_ready_I),
        .mem_read_D(mem_read_D), .mem_write_D(mem_write_D),
        .mem_addr_D(mem_addr_D), .mem_wdata_D(mem_wdata_D),
        .mem_rdata_D(mem_rdata_D), .mem_ready_D(mem_ready_D),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .grant(grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected memory-side transaction, in expected grant order.
    typedef struct {
        bit            p;          // 0 = I, 1 = D
        bit            rd;
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            after_prev; // waits behind another grant
        int            req_edge;   // edge that first samples the request
    } txn_t;

    txn_t exp_q[$];
    txn_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_ready_edge = -100;
    bit   prev_act = 0;
    bit   owner_i = 0, owner_d = 0;
    bit   in_rst_test = 0;
    bit   mem_auto = 1;
    int   lat_fixed = 0;
    int   stray_cnt = 0, stray_done = 0;
    bit   dfav = 1;   // model: D wins the next tie

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Memory model: answers each request after a latency, plus stray pulses on demand.
    initial begin
        int lat;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (stray_cnt != stray_done) begin
                mem_rdata = rnd128();
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
                stray_done++;
            end else if (mem_auto && (mem_read || mem_write)) begin
                lat = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(3, 8));
                repeat (lat - 1) @(negedge clk);
                mem_rdata = rnd128();
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
            end
        end
    end

    // Monitor, memory side: each new transaction pops the scoreboard.
    initial begin
        txn_t e;
        bit   act;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            act = mem_read | mem_write;
            if (act && !prev_act) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", {126'b0, grant}, 128'h0);
                end else begin
                    e   = exp_q.pop_front();
                    cur = e;
                    chk("grant_cycle", DW'(cyc), DW'(e.after_prev ? last_ready_edge + 2 : e.req_edge));
                    chk("grant", {126'b0, grant}, e.p ? 128'h2 : 128'h1);
                    chk("mem_read", {127'b0, mem_read}, {127'b0, e.rd});
                    chk("mem_write", {127'b0, mem_write}, {127'b0, e.wr});
                    chk("mem_addr", {100'b0, mem_addr}, {100'b0, e.a});
                    chk("mem_wdata", mem_wdata, e.d);
                end
            end else if (act) begin
                chk("hold_grant", {126'b0, grant}, cur.p ? 128'h2 : 128'h1);
                chk("hold_addr", {100'b0, mem_addr}, {100'b0, cur.a});
                chk("hold_wdata", mem_wdata, cur.d);
            end else begin
                chk("idle_grant", {126'b0, grant}, 128'h0);
                if (prev_act && !in_rst_test)
                    chk("clear_edge", DW'(cyc), DW'(last_ready_edge));
            end
            prev_act = act;
            owner_i  = act && !cur.p;
            owner_d  = act && cur.p;
        end
    end

    // Monitor, cache side: ready steering and read-data broadcast.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mem_ready) begin
                chk("ready_I", {127'b0, mem_ready_I}, {127'b0, owner_i});
                chk("ready_D", {127'b0, mem_ready_D}, {127'b0, owner_d});
                chk("rdata_I", mem_rdata_I, mem_rdata);
                chk("rdata_D", mem_rdata_D, mem_rdata);
                if (owner_i || owner_d) last_ready_edge = cyc + 1;
            end else begin
                chk("no_ready", {126'b0, mem_ready_I, mem_ready_D}, 128'h0);
            end
        end
    end

    // Cache driver: raise request, hold until ready, drop one cycle later.
    task automatic drive(input bit p, input logic [1:0] code, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input int dly);
        int  n;
        bit  done;
        repeat (dly) @(negedge clk);
        if (p) begin
            mem_read_D = code[0]; mem_write_D = code[1]; mem_addr_D = a; mem_wdata_D = d;
        end else begin
            mem_read_I = code[0]; mem_write_I = code[1]; mem_addr_I = a; mem_wdata_I = d;
        end
        n = 0;
        done = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            #2;
            done = p ? mem_ready_D : mem_ready_I;
            n++;
        end
        if (!done) chk("ready_timeout", 128'h0, 128'h1);
        @(negedge clk);
        if (p) begin mem_read_D = 0; mem_write_D = 0; end
        else   begin mem_read_I = 0; mem_write_I = 0; end
    endtask

    function automatic txn_t mk(input bit p, input logic [1:0] code, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input bit after, input int re);
        txn_t t;
        t.p = p; t.wr = code[1]; t.rd = code[0] & ~code[1];
        t.a = a; t.d = d; t.after_prev = after; t.req_edge = re;
        return t;
    endfunction

    // mode 0: I only, 1: D only, 2: both together, 3: I then D while I is granted.
    task automatic run_round(input int mode, input logic [1:0] ci, input logic [AW-1:0] ai,
                             input logic [DW-1:0] di, input logic [1:0] cd,
                             input logic [AW-1:0] ad, input logic [DW-1:0] dd);
        int  re;
        bit  d_first;
        re = cyc + 1;
        case (mode)
            0: begin exp_q.push_back(mk(0, ci, ai, di, 0, re)); dfav = 1; end
            1: begin exp_q.push_back(mk(1, cd, ad, dd, 0, re)); dfav = 0; end
            2: begin
`ifdef ARB_RR_EN
                d_first = dfav;
`else
                d_first = 1;
`endif
                if (d_first) begin
                    exp_q.push_back(mk(1, cd, ad, dd, 0, re));
                    exp_q.push_back(mk(0, ci, ai, di, 1, re));
                    dfav = 1;
                end else begin
                    exp_q.push_back(mk(0, ci, ai, di, 0, re));
                    exp_q.push_back(mk(1, cd, ad, dd, 1, re));
                    dfav = 0;
                end
            end
            default: begin
                exp_q.push_back(mk(0, ci, ai, di, 0, re));
                exp_q.push_back(mk(1, cd, ad, dd, 1, re));
                dfav = 0;
            end
        endcase
        fork
            begin if (mode != 1) drive(0, ci, ai, di, 0); end
            begin if (mode != 0) drive(1, cd, ad, dd, (mode == 3) ? 2 : 0); end
        join
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] a5;
        a5 = {16{8'hA5}};
        rst_n = 1'b0;
        mem_read_I = 0; mem_write_I = 0; mem_addr_I = '0; mem_wdata_I = '0;
        mem_read_D = 0; mem_write_D = 0; mem_addr_D = '0; mem_wdata_D = '0;
        #2;
        chk("rst_mem_read", {127'b0, mem_read}, 128'h0);
        chk("rst_mem_write", {127'b0, mem_write}, 128'h0);
        chk("rst_mem_addr", {100'b0, mem_addr}, 128'h0);
        chk("rst_mem_wdata", mem_wdata, 128'h0);
        chk("rst_grant", {126'b0, grant}, 128'h0);
        chk("rst_ready", {126'b0, mem_ready_I, mem_ready_D}, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases.
        lat_fixed = 5;
        run_round(0, 2'b01, 28'h0000010, rnd128(), 2'b00, '0, '0);
        run_round(1, 2'b00, '0, '0, 2'b10, 28'h0000020, a5);
        run_round(2, 2'b01, 28'h0000111, rnd128(), 2'b01, 28'h0000222, rnd128());
        run_round(3, 2'b10, 28'h0000333, rnd128(), 2'b01, 28'h0000444, rnd128());
        run_round(1, 2'b00, '0, '0, 2'b11, 28'h0000555, rnd128());  // read+write together
        for (int i = 0; i < 4; i++)
            run_round(2, 2'b01, 28'(i), rnd128(), 2'b10, 28'(i + 16), rnd128());

        // Randomized rounds.
        lat_fixed = 0;
        for (int i = 0; i < 40; i++)
            run_round(int'($urandom_range(0, 3)),
                      2'($urandom_range(1, 3)), 28'($urandom), rnd128(),
                      2'($urandom_range(1, 3)), 28'($urandom), rnd128());

        // Reset mid GNT_D.
        mem_auto = 0;
        exp_q.push_back(mk(1, 2'b01, 28'h0ABCDEF, a5, 0, cyc + 1));
        mem_read_D = 1; mem_addr_D = 28'h0ABCDEF; mem_wdata_D = a5;
        repeat (3) @(negedge clk);
        in_rst_test = 1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_read", {127'b0, mem_read}, 128'h0);
        chk("mid_rst_write", {127'b0, mem_write}, 128'h0);
        chk("mid_rst_grant", {126'b0, grant}, 128'h0);
        chk("mid_rst_addr", {100'b0, mem_addr}, 128'h0);
        mem_read_D = 0;
        @(negedge clk);
        rst_n = 1'b1;
        dfav = 1;
        @(posedge clk);
        stray_cnt++;
        for (int n = 0; n < 20 && stray_done != stray_cnt; n++) @(negedge clk);
        chk("stray_served", DW'(stray_done), DW'(stray_cnt));
        repeat (2) @(negedge clk);
        in_rst_test = 0;
        mem_auto = 1;
        run_round(2, 2'b01, 28'h0000777, rnd128(), 2'b10, 28'h0000888, rnd128());

        repeat (4) @(negedge clk);
        chk("queue_drained", DW'(exp_q.size()), 128'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
